// File: rtl/lkup_rrarb.sv
// Round-robin arbiter for the lookup scheduler.
//
// Grants at most one requester per cycle, searching from the index just after
// the last granted one. The last-grant pointer only moves when a grant is
// actually consumed (advance high while a request is present), so a requester
// that was just served drops to lowest priority.
//
// Ports:
//   i_clk      clock
//   i_reset_n  synchronous active-low reset (pointer -> W-1, so index 0 wins first)
//   request    per-requester request bits
//   advance    consume the current grant and move the pointer
//   grant      one-hot grant (all zero when nothing is requested)
module lkup_rrarb #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] request,
  input  logic         advance,
  output logic [W-1:0] grant
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters in priority order starting after last_q; the first
  // hit wins and becomes the candidate new pointer value.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= W; k++) begin
      idx = PW'((int'(last_q) + k) % W);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        last_d     = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      last_q <= PW'(W - 1);
    end else if (advance && found) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rtlkup_sched.sv
// Routing-table lookup scheduler.
//
// Serialises destination-MAC lookups from NREQ requesters onto a single
// routing-table port. Broadcast MACs bypass the table; every other request is
// presented to the table and guarded by a watchdog that substitutes
// DEFAULT_PORT if the table never answers. The ingress port is always removed
// from the returned egress mask so a packet is never reflected.
//
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   REQ_VALID/DSTMAC/SRCPORT per-requester lookup request (held until REQ_ACK)
//   REQ_ACK, RSP_PORT        one-cycle completion pulse and egress mask
//   TBL_VALID/DSTMAC         request to the routing table
//   TBL_ACK, TBL_PORT        routing-table completion and result mask
//   o_timeout                pulse when the watchdog gives up on the table
module rtlkup_sched #(
  parameter int              NREQ           = 4,
  parameter int              NETH           = 4,
  parameter int              MACW           = 48,
  localparam int             LGETH          = (NETH > 1) ? $clog2(NETH) : 1,
  parameter logic [NETH-1:0] BROADCAST_PORT = {NETH{1'b1}},
  parameter logic [NETH-1:0] DEFAULT_PORT   = BROADCAST_PORT,
  parameter int              LGWDOG         = 5,
  parameter bit              OPT_LOWPOWER   = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*MACW-1:0]  REQ_DSTMAC,
  input  logic [NREQ*LGETH-1:0] REQ_SRCPORT,
  output logic [NREQ-1:0]       REQ_ACK,
  output logic [NETH-1:0]       RSP_PORT,
  output logic                  TBL_VALID,
  output logic [MACW-1:0]       TBL_DSTMAC,
  input  logic                  TBL_ACK,
  input  logic [NETH-1:0]       TBL_PORT,
  output logic                  o_timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [LGWDOG-1:0] WDOG_MAX  = '1;
  localparam logic [MACW-1:0]   MAC_BCAST = '1;

  logic [MACW-1:0]  req_mac [NREQ];
  logic [LGETH-1:0] req_src [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_mac[gi] = REQ_DSTMAC[gi*MACW +: MACW];
      assign req_src[gi] = REQ_SRCPORT[gi*LGETH +: LGETH];
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [LGETH-1:0]  src_q, src_d;
  logic              tbl_valid_q, tbl_valid_d;
  logic [MACW-1:0]   tbl_mac_q, tbl_mac_d;
  logic [NETH-1:0]   rsp_q, rsp_d;
  logic [LGWDOG-1:0] wdog_q, wdog_d;
  logic              timeout_c;

  logic [NREQ-1:0]   arb_grant;
  logic              arb_adv;
  logic [MACW-1:0]   gnt_mac;
  logic [LGETH-1:0]  gnt_src;
  logic [NETH-1:0]   gnt_keep;
  logic [NETH-1:0]   cur_keep;

  lkup_rrarb #(.W(NREQ)) u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .request   (REQ_VALID),
    .advance   (arb_adv),
    .grant     (arb_grant)
  );

  // Select the granted requester's MAC and ingress port.
  always_comb begin
    gnt_mac = '0;
    gnt_src = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        gnt_mac = req_mac[i];
        gnt_src = req_src[i];
      end
    end
  end

  // Masks that strip the ingress port from any egress result.
  assign gnt_keep = ~(NETH'(1) << gnt_src);
  assign cur_keep = ~(NETH'(1) << src_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    src_d       = src_q;
    tbl_valid_d = tbl_valid_q;
    tbl_mac_d   = tbl_mac_q;
    rsp_d       = OPT_LOWPOWER ? '0 : rsp_q;
    wdog_d      = wdog_q;
    timeout_c   = 1'b0;
    arb_adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          arb_adv = 1'b1;
          sel_d   = arb_grant;
          src_d   = gnt_src;
          if (gnt_mac == MAC_BCAST) begin
            rsp_d   = BROADCAST_PORT & gnt_keep;
            state_d = S_RESPOND;
          end else begin
            tbl_mac_d   = gnt_mac;
            tbl_valid_d = 1'b1;
            wdog_d      = '0;
            state_d     = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        // A table answer in the same cycle as the watchdog limit takes priority.
        if (TBL_ACK) begin
          rsp_d       = TBL_PORT & cur_keep;
          tbl_valid_d = 1'b0;
          state_d     = S_RESPOND;
        end else if (wdog_q == WDOG_MAX) begin
          timeout_c   = 1'b1;
          rsp_d       = DEFAULT_PORT & cur_keep;
          tbl_valid_d = 1'b0;
          state_d     = S_RESPOND;
        end else begin
          wdog_d = wdog_q + LGWDOG'(1);
        end
        if (OPT_LOWPOWER && (state_d != S_LOOKUP)) begin
          tbl_mac_d = '0;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      src_q       <= '0;
      tbl_valid_q <= 1'b0;
      tbl_mac_q   <= '0;
      rsp_q       <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      src_q       <= src_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_mac_q   <= tbl_mac_d;
      rsp_q       <= rsp_d;
      wdog_q      <= wdog_d;
    end
  end

  assign REQ_ACK    = (state_q == S_RESPOND) ? sel_q : '0;
  assign RSP_PORT   = rsp_q;
  assign TBL_VALID  = tbl_valid_q;
  assign TBL_DSTMAC = tbl_mac_q;
  // The FSM may still be in LOOKUP during the reset cycle; keep the pulse quiet.
  assign o_timeout  = timeout_c & i_reset_n;

endmodule

// File: tb/tb_rtlkup_sched.sv
// Testbench for rtlkup_sched: directed scenarios plus randomized traffic,
// compared against a transaction-level model that predicts grant order,
// event cycles and egress masks from the scheduling rules.
module tb_rtlkup_sched;

  localparam int NREQ   = 4;
  localparam int NETH   = 4;
  localparam int MACW   = 48;
  localparam int LGETH  = 2;
  localparam int LGWDOG = 5;
  localparam int WD     = 1 << LGWDOG;
  localparam logic [NETH-1:0] BCAST    = 4'b1111;
  localparam logic [MACW-1:0] MAC_ALL1 = {MACW{1'b1}};

  logic                  i_clk;
  logic                  i_reset_n;
  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ*MACW-1:0]  REQ_DSTMAC;
  logic [NREQ*LGETH-1:0] REQ_SRCPORT;
  logic [NREQ-1:0]       REQ_ACK;
  logic [NETH-1:0]       RSP_PORT;
  logic                  TBL_VALID;
  logic [MACW-1:0]       TBL_DSTMAC;
  logic                  TBL_ACK;
  logic [NETH-1:0]       TBL_PORT;
  logic                  o_timeout;

  rtlkup_sched #(
    .NREQ           (NREQ),
    .NETH           (NETH),
    .MACW           (MACW),
    .BROADCAST_PORT (BCAST),
    .DEFAULT_PORT   (BCAST),
    .LGWDOG         (LGWDOG),
    .OPT_LOWPOWER   (1'b0)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .REQ_VALID   (REQ_VALID),
    .REQ_DSTMAC  (REQ_DSTMAC),
    .REQ_SRCPORT (REQ_SRCPORT),
    .REQ_ACK     (REQ_ACK),
    .RSP_PORT    (RSP_PORT),
    .TBL_VALID   (TBL_VALID),
    .TBL_DSTMAC  (TBL_DSTMAC),
    .TBL_ACK     (TBL_ACK),
    .TBL_PORT    (TBL_PORT),
    .o_timeout   (o_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ncyc     = 0;

  bit              mon_en       = 1'b0;
  bit              tbl_ack_en   = 1'b1;
  bit              force_ack    = 1'b0;
  bit              rand_tbl     = 1'b0;
  logic [NETH-1:0] tbl_port_val = '0;

  bit               req_v   [NREQ];
  logic [MACW-1:0]  req_mac [NREQ];
  logic [LGETH-1:0] req_src [NREQ];

  // Model state: one outstanding transaction, described by its event cycles.
  bit              m_busy;
  int              m_last;
  int              m_idle_at;
  int              e_idx, e_ack, e_tv_from, e_tv_to, e_to;
  logic [NETH-1:0] e_rsp;
  logic [MACW-1:0] e_mac;
  int              ack_order[$];
  int              ack_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, errors %0d", n_errors);
    $fatal(1);
  end

  // Routing-table model and per-cycle invariants, evaluated just after each edge.
  initial begin : table_mon
    bit ack_pend;
    bit prev_v;
    ack_pend = 1'b0;
    prev_v   = 1'b0;
    TBL_ACK  = 1'b0;
    TBL_PORT = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (mon_en) begin
        if (TBL_ACK) check("tblv_after_ack", TBL_VALID, 0);
        check("ack_onehot", $countones(REQ_ACK) <= 1, 1);
        check("ack_has_valid", REQ_ACK & ~REQ_VALID, 0);
      end
      TBL_ACK   = ack_pend | force_ack;
      force_ack = 1'b0;
      TBL_PORT  = tbl_port_val;
      ack_pend  = TBL_VALID && !prev_v && tbl_ack_en;
      prev_v    = TBL_VALID;
    end
  end

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]                     = req_v[i];
      REQ_DSTMAC[i*MACW +: MACW]       = req_mac[i];
      REQ_SRCPORT[i*LGETH +: LGETH]    = req_src[i];
    end
  endtask

  task automatic post(input int i, input logic [MACW-1:0] mac, input int src);
    req_v[i]   = 1'b1;
    req_mac[i] = mac;
    req_src[i] = LGETH'(src);
  endtask

  task automatic rand_post(input int i);
    logic [MACW-1:0] mac;
    if ($urandom_range(0, 5) == 0) mac = MAC_ALL1;
    else mac = {8'h02, 8'($urandom_range(0, 255)), 32'($urandom)};
    post(i, mac, $urandom_range(0, NETH - 1));
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_last    = NREQ - 1;
    m_idle_at = ncyc + 1;
  endtask

  // Compare this cycle's outputs against the outstanding transaction.
  task automatic model_check();
    logic [NREQ-1:0] exp_ack;
    bit acking;
    bit exp_tv;
    acking  = m_busy && (ncyc == e_ack);
    exp_ack = acking ? (NREQ'(1) << e_idx) : '0;
    check("req_ack", REQ_ACK, exp_ack);
    if (acking) check("rsp_port", RSP_PORT, e_rsp);
    exp_tv = m_busy && (ncyc >= e_tv_from) && (ncyc <= e_tv_to);
    check("tbl_valid", TBL_VALID, exp_tv);
    if (exp_tv) check("tbl_dstmac", TBL_DSTMAC, e_mac);
    check("timeout", o_timeout, m_busy && (ncyc == e_to));
    if (acking) begin
      $display("txn: req %0d mac %h rsp_port %b ack_cycle %0d", e_idx, e_mac, RSP_PORT, ncyc);
      ack_order.push_back(e_idx);
      ack_cyc.push_back(ncyc);
      req_v[e_idx] = 1'b0;
      m_busy       = 1'b0;
      m_idle_at    = ncyc + 1;
    end
  endtask

  // Cycle ncyc is "cycle 0" of a new transaction when the scheduler is idle
  // and some request is pending at the end of it.
  task automatic model_decide();
    int pick;
    logic [NETH-1:0] keep;
    if (m_busy || (ncyc < m_idle_at) || !i_reset_n) return;
    pick = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (pick < 0 && req_v[i]) pick = i;
    end
    if (pick < 0) return;
    if (rand_tbl) tbl_port_val = NETH'($urandom_range(0, 15));
    keep   = ~(NETH'(1) << req_src[pick]);
    m_busy = 1'b1;
    m_last = pick;
    e_idx  = pick;
    e_mac  = req_mac[pick];
    e_to   = -1;
    if (req_mac[pick] == MAC_ALL1) begin
      e_ack     = ncyc + 1;
      e_tv_from = ncyc + 1;
      e_tv_to   = ncyc;
      e_rsp     = BCAST & keep;
    end else if (tbl_ack_en) begin
      e_tv_from = ncyc + 1;
      e_tv_to   = ncyc + 2;
      e_ack     = ncyc + 3;
      e_rsp     = tbl_port_val & keep;
    end else begin
      e_tv_from = ncyc + 1;
      e_tv_to   = ncyc + WD;
      e_to      = ncyc + WD;
      e_ack     = ncyc + WD + 1;
      e_rsp     = BCAST & keep;
    end
  endtask

  task automatic cycle_begin();
    @(negedge i_clk);
    ncyc++;
    model_check();
  endtask

  task automatic cycle_end();
    apply();
    model_decide();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  // Wait for the current transaction to finish, then withdraw all requests.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      cycle_begin();
      if (!m_busy) begin
        for (int i = 0; i < NREQ; i++) req_v[i] = 1'b0;
        done = 1'b1;
      end
      cycle_end();
    end
    check("drain", done, 1);
  endtask

  initial begin : main
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    i_reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i]   = 1'b0;
      req_mac[i] = '0;
      req_src[i] = '0;
    end
    apply();
    model_reset();
    m_idle_at = 0;

    run(3);
    check("rst_req_ack", REQ_ACK, 0);
    check("rst_tbl_valid", TBL_VALID, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_rsp_port", RSP_PORT, 0);
    check("rst_tbl_dstmac", TBL_DSTMAC, 0);
    cycle_begin();
    i_reset_n = 1'b1;
    mon_en    = 1'b1;
    cycle_end();

    // Single table lookup: requester 0, ingress 0, table answers 0100.
    cycle_begin();
    tbl_port_val = 4'b0100;
    post(0, 48'h02_00_00_00_00_05, 0);
    cycle_end();
    run(5);

    // Broadcast from requester 2 on ingress 2 bypasses the table.
    cycle_begin();
    post(2, MAC_ALL1, 2);
    cycle_end();
    run(3);

    // Table never answers: watchdog fires, then a stray late ack is ignored.
    cycle_begin();
    tbl_ack_en = 1'b0;
    post(3, 48'h02_00_00_00_01_23, 3);
    cycle_end();
    run(WD + 4);
    cycle_begin();
    force_ack = 1'b1;
    cycle_end();
    run(4);
    tbl_ack_en = 1'b1;

    // All four requesters held continuously, table answers 0010.
    ack_order.delete();
    ack_cyc.delete();
    tbl_port_val = 4'b0010;
    for (int t = 0; t < 21; t++) begin
      cycle_begin();
      for (int i = 0; i < NREQ; i++)
        if (!req_v[i]) post(i, {8'h02, 8'(i), 32'h0000_1000 + 32'(t)}, i);
      cycle_end();
    end
    drain();
    for (int j = 0; j < 5; j++) begin
      check("grant_order", (j < ack_order.size()) ? ack_order[j] : 99, exp_ord[j]);
      if (j > 0)
        check("ack_spacing", (j < ack_cyc.size()) ? (ack_cyc[j] - ack_cyc[j-1]) : 0, 4);
    end
    run(2);

    // Reset for one cycle in the middle of a lookup.
    cycle_begin();
    tbl_port_val = 4'b1111;
    post(0, 48'h02_00_00_00_0a_0b, 1);
    cycle_end();
    cycle_begin();
    i_reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) req_v[i] = 1'b0;
    model_reset();
    cycle_end();
    cycle_begin();
    i_reset_n = 1'b1;
    cycle_end();
    run(4);
    cycle_begin();
    tbl_port_val = 4'b1001;
    post(2, 48'h02_00_00_00_0c_0d, 0);
    cycle_end();
    run(5);

    // Randomized traffic, including withdrawn requests and immediate re-requests.
    rand_tbl = 1'b1;
    repeat (400) begin
      cycle_begin();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) rand_post(i);
        end else if (!(m_busy && e_idx == i) && $urandom_range(0, 15) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      cycle_end();
    end
    drain();
    run(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
